// File: rtl/wb_pkg.sv
// wb_pkg: shared types and constants for the register file writeback path.
//   wb_req_t  - one register file write request (enable, address, data)
//   NUM_REGS  - number of integer registers (x0 is hardwired zero)
//   XLEN      - register width
//   RA_W      - register address width
//   pend_hit  - scoreboard lookup with x0 masked out
package wb_pkg;

  localparam int NUM_REGS = 32;
  localparam int XLEN     = 32;
  localparam int RA_W     = $clog2(NUM_REGS);

  typedef struct packed {
    logic            we;
    logic [4:0]      rd_s;
    logic [31:0]     rd_v;
  } wb_req_t;

  // x0 never has an outstanding result, whatever the vector holds.
  function automatic logic pend_hit(input logic [NUM_REGS-1:0] p,
                                    input logic [RA_W-1:0]     idx);
    return (idx != '0) && p[idx];
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: small synchronous FIFO of wb_req_t entries.
//   clk, rst     - clock, asynchronous active-low reset (empties the FIFO)
//   push         - write push_data when not full
//   push_data    - entry to store
//   pop          - discard the head entry when not empty
//   head         - current head entry (valid only when !empty)
//   full, empty  - occupancy flags, decoded from registered pointers only
// Pointers carry one extra wrap bit so full and empty are distinguishable
// without a separate counter.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  wb_req_t push_data,
  input  logic    pop,
  output wb_req_t head,
  output logic    full,
  output logic    empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wptr;
  logic [AW:0] rptr;
  wb_req_t     mem [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // Storage is not reset: reset only moves the pointers, which makes any
  // stale contents unreachable.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/regfile_wb_arb.sv
// regfile_wb_arb: drives the integer register file write port from two
// sources.
//   clk, rst                 - clock, asynchronous active-low reset
//   pipe_we/rd_s/rd_v        - in-order pipeline WB request (no backpressure)
//   pipe_hold                - pipeline must not present pipe_we this cycle
//   md_valid/ready/rd_s/rd_v - mul/div result handshake into the FIFO
//   iss_valid, iss_rd_s      - decode issues a mul/div op writing iss_rd_s
//   dec_rs1_s/rs2_s/rd_s     - decode operands checked against the scoreboard
//   hazard                   - decode must stall
//   pend                     - registers awaiting a mul/div result
//   regf_we, rd_s, rd_v      - registered register file write port
//
// Handshake: an md result transfers on a rising edge where md_valid and
// md_ready are both high; md_ready depends only on registered FIFO state
// (not full at the start of the cycle), and md_rd_s/md_rd_v must be stable
// while md_valid is high.
//
// The pipeline normally wins the write port. The FIFO head wins when the
// pipeline is idle or when pipe_hold is asserted; pipe_hold rises after the
// head has lost arbitration STARVE_MAX times in a row.
module regfile_wb_arb
  import wb_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_rd_s,
  input  logic [31:0] pipe_rd_v,
  output logic        pipe_hold,
  input  logic        md_valid,
  output logic        md_ready,
  input  logic [4:0]  md_rd_s,
  input  logic [31:0] md_rd_v,
  input  logic        iss_valid,
  input  logic [4:0]  iss_rd_s,
  input  logic [4:0]  dec_rs1_s,
  input  logic [4:0]  dec_rs2_s,
  input  logic [4:0]  dec_rd_s,
  output logic        hazard,
  output logic [31:0] pend,
  output logic        regf_we,
  output logic [4:0]  rd_s,
  output logic [31:0] rd_v
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  wb_req_t       md_req;
  wb_req_t       head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          md_push;
  logic          fifo_pop;
  logic          pipe_req;
  logic          pipe_win;
  logic [SW-1:0] starve_cnt;
  logic [31:0]   pend_nxt;

  // ---------------------------------------------------------------------
  // Mul/div result FIFO
  // ---------------------------------------------------------------------
  assign md_ready = !fifo_full;
  assign md_push  = md_valid && md_ready;

  // A result to x0 is still queued so the producer is released, but it is
  // tagged we=0 so it never reaches the register file or the scoreboard.
  assign md_req = '{we: (md_rd_s != 5'd0), rd_s: md_rd_s, rd_v: md_rd_v};

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (md_push),
    .push_data (md_req),
    .pop       (fifo_pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // ---------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------
  // A pipe write to x0 is not a request at all. While pipe_hold is high
  // the pipeline request is ignored outright.
  assign pipe_req = pipe_we && (pipe_rd_s != 5'd0);
  assign pipe_win = pipe_req && !pipe_hold;
  assign fifo_pop = !fifo_empty && !pipe_win;

  // Decoded from the counter register only, so the pipeline sees it early
  // in the cycle with no path from this cycle's inputs.
  assign pipe_hold = (starve_cnt == STARVE_LIM);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regf_we <= 1'b0;
      rd_s    <= 5'd0;
      rd_v    <= 32'd0;
    end else if (pipe_win) begin
      regf_we <= 1'b1;
      rd_s    <= pipe_rd_s;
      rd_v    <= pipe_rd_v;
    end else if (fifo_pop) begin
      regf_we <= head.we;
      rd_s    <= head.rd_s;
      rd_v    <= head.rd_v;
    end else begin
      regf_we <= 1'b0;
      rd_s    <= 5'd0;
      rd_v    <= 32'd0;
    end
  end

  // ---------------------------------------------------------------------
  // Starvation counter: counts consecutive losses of a waiting head entry.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (fifo_pop || fifo_empty) begin
      starve_cnt <= '0;
    end else if (pipe_win && (starve_cnt != STARVE_LIM)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Pending-destination scoreboard
  // ---------------------------------------------------------------------
  // The set is applied after the clear so that a new issue to the same
  // register as the retiring result keeps the bit set.
  always_comb begin
    pend_nxt = pend;
    if (fifo_pop && head.we) pend_nxt[head.rd_s] = 1'b0;
    if (iss_valid && (iss_rd_s != 5'd0)) pend_nxt[iss_rd_s] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend <= 32'd0;
    end else begin
      pend <= pend_nxt;
    end
  end

  assign hazard = pend_hit(pend, dec_rs1_s) |
                  pend_hit(pend, dec_rs2_s) |
                  pend_hit(pend, dec_rd_s);

endmodule

// File: tb/tb_regfile_wb_arb.sv
// tb_regfile_wb_arb: directed bench for regfile_wb_arb with an expected-write
// queue checked by an independent monitor on the falling clock edge.
module tb_regfile_wb_arb;

  localparam int W = 37;

  logic        clk;
  logic        rst;
  logic        pipe_we;
  logic [4:0]  pipe_rd_s;
  logic [31:0] pipe_rd_v;
  logic        pipe_hold;
  logic        md_valid;
  logic        md_ready;
  logic [4:0]  md_rd_s;
  logic [31:0] md_rd_v;
  logic        iss_valid;
  logic [4:0]  iss_rd_s;
  logic [4:0]  dec_rs1_s;
  logic [4:0]  dec_rs2_s;
  logic [4:0]  dec_rd_s;
  logic        hazard;
  logic [31:0] pend;
  logic        regf_we;
  logic [4:0]  rd_s;
  logic [31:0] rd_v;

  logic [W-1:0] exp_q[$];
  int           exp_cyc_q[$];
  int           cyc;
  int           n_chk;
  int           n_fail;

  regfile_wb_arb #(
    .DEPTH      (4),
    .STARVE_MAX (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pipe_we   (pipe_we),
    .pipe_rd_s (pipe_rd_s),
    .pipe_rd_v (pipe_rd_v),
    .pipe_hold (pipe_hold),
    .md_valid  (md_valid),
    .md_ready  (md_ready),
    .md_rd_s   (md_rd_s),
    .md_rd_v   (md_rd_v),
    .iss_valid (iss_valid),
    .iss_rd_s  (iss_rd_s),
    .dec_rs1_s (dec_rs1_s),
    .dec_rs2_s (dec_rs2_s),
    .dec_rd_s  (dec_rd_s),
    .hazard    (hazard),
    .pend      (pend),
    .regf_we   (regf_we),
    .rd_s      (rd_s),
    .rd_v      (rd_v)
  );

  // ---------------------------------------------------------------------
  // Clock and cycle counter
  // ---------------------------------------------------------------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pipe_we   = 1'b0;
    pipe_rd_s = 5'd0;
    pipe_rd_v = 32'd0;
    md_valid  = 1'b0;
    md_rd_s   = 5'd0;
    md_rd_v   = 32'd0;
    iss_valid = 1'b0;
    iss_rd_s  = 5'd0;
    dec_rs1_s = 5'd0;
    dec_rs2_s = 5'd0;
    dec_rd_s  = 5'd0;
  endtask

  task automatic drive_pipe(input logic [4:0] rd, input logic [31:0] v);
    pipe_we   = 1'b1;
    pipe_rd_s = rd;
    pipe_rd_v = v;
  endtask

  task automatic drive_md(input logic [4:0] rd, input logic [31:0] v);
    md_valid = 1'b1;
    md_rd_s  = rd;
    md_rd_v  = v;
  endtask

  task automatic drive_iss(input logic [4:0] rd);
    iss_valid = 1'b1;
    iss_rd_s  = rd;
  endtask

  task automatic expect_wr(input logic [4:0] rd, input logic [31:0] v, input int at);
    exp_q.push_back({rd, v});
    exp_cyc_q.push_back(at);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------
  // Scoreboard monitor: every register file write must match the head of
  // the expected queue, in data and in cycle.
  // ---------------------------------------------------------------------
  always @(negedge clk) begin
    if (regf_we) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got rd=%0d v=0x%08h at cycle %0d, expected no write",
                 rd_s, rd_v, cyc);
      end else begin
        logic [W-1:0] e;
        int           ec;
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        if (({rd_s, rd_v} !== e) || (cyc != ec)) begin
          n_fail++;
          $display("FAIL write: got rd=%0d v=0x%08h cycle %0d, expected rd=%0d v=0x%08h cycle %0d",
                   rd_s, rd_v, cyc, e[36:32], e[31:0], ec);
        end
      end
    end
  end

  // Pipeline protocol: no request while the hold is up.
  always @(negedge clk) begin
    if (rst && pipe_hold && pipe_we) begin
      n_fail++;
      $display("FAIL protocol: pipe_we=1 while pipe_hold=1 at cycle %0d, expected pipe_we=0", cyc);
    end
  end

  // Watchdog.
  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // ---------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------
  initial begin
    logic hold_exp;
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b0;
    idle();

    // Reset state.
    tick();
    tick();
    chk("rst_regf_we",   32'(regf_we),   32'd0);
    chk("rst_rd_s",      32'(rd_s),      32'd0);
    chk("rst_rd_v",      rd_v,           32'd0);
    chk("rst_pend",      pend,           32'd0);
    chk("rst_pipe_hold", 32'(pipe_hold), 32'd0);
    chk("rst_md_ready",  32'(md_ready),  32'd1);
    chk("rst_hazard",    32'(hazard),    32'd0);
    rst = 1'b1;
    tick();

    // Pipe-only: one-cycle latency; a write to x0 is dropped.
    idle();
    drive_pipe(5'd5, 32'hDEADBEEF);
    expect_wr(5'd5, 32'hDEADBEEF, cyc + 1);
    tick();
    chk("pipe_regf_we", 32'(regf_we), 32'd1);
    chk("pipe_rd_s",    32'(rd_s),    32'd5);
    idle();
    drive_pipe(5'd0, 32'h55);
    tick();
    chk("pipe_x0_we", 32'(regf_we), 32'd0);
    idle();
    tick();

    // MD path: issue sets pend, handshake at t writes at t+2 and clears pend.
    idle();
    drive_iss(5'd7);
    tick();
    idle();
    chk("md_pend_set", pend, 32'h0000_0080);
    drive_md(5'd7, 32'h1234);
    expect_wr(5'd7, 32'h1234, cyc + 2);
    tick();
    idle();
    chk("md_pend_wait", pend, 32'h0000_0080);
    tick();
    chk("md_regf_we",    32'(regf_we), 32'd1);
    chk("md_pend_clear", pend,         32'd0);
    tick();

    // Starvation: one entry waits while the pipe writes every cycle.
    idle();
    drive_md(5'd10, 32'hA0A0);
    tick();
    idle();
    chk("starve_hold0", 32'(pipe_hold), 32'd0);
    drive_pipe(5'd1, 32'h11);
    expect_wr(5'd1, 32'h11, cyc + 1);
    tick();
    idle();
    drive_pipe(5'd2, 32'h12);
    expect_wr(5'd2, 32'h12, cyc + 1);
    tick();
    idle();
    chk("starve_hold2", 32'(pipe_hold), 32'd0);
    drive_pipe(5'd3, 32'h13);
    expect_wr(5'd3, 32'h13, cyc + 1);
    tick();
    idle();
    chk("starve_hold3", 32'(pipe_hold), 32'd1);
    expect_wr(5'd10, 32'hA0A0, cyc + 1);
    tick();
    idle();
    chk("starve_release", 32'(pipe_hold), 32'd0);
    drive_pipe(5'd4, 32'h14);
    expect_wr(5'd4, 32'h14, cyc + 1);
    tick();
    idle();
    tick();

    // Full FIFO: four results pushed under continuous pipe traffic; a fifth
    // offered while full must be refused.
    for (int i = 0; i < 18; i++) begin
      idle();
      hold_exp = (i >= 4) && (i % 4 == 0);
      chk("full_hold", 32'(pipe_hold), 32'(hold_exp));
      if (i == 3) chk("full_ready_3", 32'(md_ready), 32'd1);
      if (i == 4) chk("full_ready_4", 32'(md_ready), 32'd0);
      if (i == 5) chk("full_ready_5", 32'(md_ready), 32'd1);
      if (i < 4) drive_md(5'(11 + i), 32'(32'hB0 + i));
      else if (i == 4) drive_md(5'd15, 32'hBAD);
      if (hold_exp) begin
        expect_wr(5'(11 + i / 4 - 1), 32'(32'hB0 + i / 4 - 1), cyc + 1);
      end else begin
        drive_pipe(5'(1 + i), 32'(32'h100 + i));
        expect_wr(5'(1 + i), 32'(32'h100 + i), cyc + 1);
      end
      tick();
    end
    idle();
    tick();
    tick();

    // Hazard and scoreboard.
    idle();
    drive_iss(5'd3);
    tick();
    idle();
    dec_rs2_s = 5'd3;
    #1;
    chk("hz_rs2", 32'(hazard), 32'd1);
    dec_rs2_s = 5'd0;
    dec_rd_s  = 5'd3;
    #1;
    chk("hz_rd", 32'(hazard), 32'd1);
    dec_rd_s = 5'd0;
    #1;
    chk("hz_x0", 32'(hazard), 32'd0);
    dec_rs1_s = 5'd4;
    dec_rs2_s = 5'd5;
    dec_rd_s  = 5'd6;
    #1;
    chk("hz_clear", 32'(hazard), 32'd0);
    chk("hz_pend", pend, 32'h0000_0008);
    tick();
    idle();
    drive_iss(5'd9);
    drive_md(5'd9, 32'h99);
    tick();
    idle();
    drive_iss(5'd9);
    expect_wr(5'd9, 32'h99, cyc + 1);
    tick();
    idle();
    chk("same_edge_pend", pend, 32'h0000_0208);
    drive_md(5'd0, 32'hFF);
    drive_iss(5'd0);
    tick();
    idle();
    tick();
    tick();
    chk("x0_pend", pend, 32'h0000_0208);

    // Reset mid-operation with two entries queued and pend non-zero.
    idle();
    drive_md(5'd12, 32'hC);
    drive_pipe(5'd1, 32'h21);
    expect_wr(5'd1, 32'h21, cyc + 1);
    tick();
    idle();
    drive_md(5'd13, 32'hD);
    drive_pipe(5'd2, 32'h22);
    expect_wr(5'd2, 32'h22, cyc + 1);
    tick();
    idle();
    drive_pipe(5'd3, 32'h23);
    expect_wr(5'd3, 32'h23, cyc + 1);
    tick();
    idle();
    #6;
    rst = 1'b0;
    #1;
    chk("arst_regf_we",   32'(regf_we),   32'd0);
    chk("arst_rd_s",      32'(rd_s),      32'd0);
    chk("arst_pend",      pend,           32'd0);
    chk("arst_md_ready",  32'(md_ready),  32'd1);
    chk("arst_pipe_hold", 32'(pipe_hold), 32'd0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    tick();
    tick();
    tick();
    chk("post_rst_pend", pend, 32'd0);
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arb.md
Name: regfile_wb_arb

Overview:
- Writeback-side driver of the integer register file write port (regf_we / rd_s / rd_v).
- Merges two result sources into the single write port:
  - the in-order pipeline WB stage, which has priority and no backpressure;
  - the multi-cycle mul/div unit, which uses a valid/ready handshake and is buffered in a small FIFO.
- Keeps a pending-destination scoreboard so decode can stall on hazards against outstanding mul/div results.

Parameters:
- DEPTH, 4, mul/div result FIFO entries (power of 2, ≥2).
- STARVE_MAX, 3, consecutive cycles the FIFO head may lose arbitration before pipe_hold asserts.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- pipe_we  in  1  pipeline WB write request.
- pipe_rd_s  in  5  pipeline destination.
- pipe_rd_v  in  32  pipeline result.
- pipe_hold  out  1  pipeline must not present pipe_we this cycle.
- md_valid  in  1  mul/div result valid.
- md_ready  out  1  FIFO can accept a result.
- md_rd_s  in  5  mul/div destination.
- md_rd_v  in  32  mul/div result.
- iss_valid  in  1  decode issues a mul/div op this cycle.
- iss_rd_s  in  5  destination of the issued op.
- dec_rs1_s, dec_rs2_s, dec_rd_s  in  5 each  decode-stage operands for hazard check.
- hazard  out  1  decode must stall.
- pend  out  32  scoreboard vector, bit i set = x<i> awaiting a mul/div result.
- regf_we  out  1  register file write enable.
- rd_s  out  5  register file write address.
- rd_v  out  32  register file write data.

Behaviour:
- Reset (rst low, asynchronous):
  - regf_we=0, rd_s=0, rd_v=0, pend=0, pipe_hold=0.
  - FIFO empty, so md_ready=1. starve_cnt=0.
- Writes to x0 are dropped everywhere:
  - pipe_we with pipe_rd_s=0 is treated as no request;
  - an md result to x0 is accepted and popped, but regf_we stays 0;
  - iss_rd_s=0 never sets pend.
- Output register: regf_we/rd_s/rd_v are registered and reload every cycle. regf_we=0 when no source is selected.
- Arbitration in cycle t (selected winner appears on the port in cycle t+1):
  - pipe_hold=0: a valid pipe request wins. Otherwise the FIFO head, if non-empty, is popped.
  - pipe_hold=1: the FIFO head wins. pipe_we high in a hold cycle is a protocol violation and is flagged by a bench assertion; RTL ignores the pipe request.
- Latency:
  - pipe request to regf_we is 1 cycle.
  - md handshake (md_valid & md_ready) at cycle t makes the entry visible at t+1. Earliest regf_we is t+2. No FIFO bypass.
- FIFO:
  - md_ready = !full.
  - Push and pop in the same cycle are legal when full: the pop frees the slot, but md_ready still reflects the start-of-cycle full state, so no push occurs that cycle.
  - Pointers are log2(DEPTH)+1 bits, wrap at 2*DEPTH, full/empty by MSB compare.
- Starvation counter:
  - starve_cnt increments when the FIFO is non-empty and the pipe wins.
  - Clears on any FIFO pop or when the FIFO is empty.
  - Saturates at STARVE_MAX.
  - pipe_hold = (starve_cnt == STARVE_MAX), registered-state decode with no combinational path from inputs.
- Scoreboard:
  - iss_valid with iss_rd_s≠0 sets pend[iss_rd_s] at the edge.
  - A FIFO pop with rd≠0 clears pend[md_rd_s of head] at the same edge.
  - Same-index set and clear on one edge: set wins.
- hazard = pend[dec_rs1_s] | pend[dec_rs2_s] | pend[dec_rd_s], with index 0 masked. Purely combinational from pend and the decode inputs.
- Ordering: a pipe write to a reg with pend set cannot occur when decode honours hazard. There is no internal WAW check.
- Reset mid-operation: FIFO contents and pend are discarded immediately; outputs return to reset values asynchronously.

Decomposition:
- Package wb_pkg:
  - typedef wb_req_t {logic we; logic [4:0] rd_s; logic [31:0] rd_v;}.
  - constants NUM_REGS=32, XLEN=32.
- One sub-module: wb_fifo, a parameterised synchronous FIFO of wb_req_t with full/empty and async active-low reset.
- Arbitration, starvation counter and scoreboard stay in the top module.

Test Plan:
- Pipe-only: pipe_we=1, rd=5, v=0xDEADBEEF at cycle 0 → regf_we=1, rd_s=5, rd_v=0xDEADBEEF at cycle 1; rd=0 request → regf_we stays 0.
- MD path: iss rd=7 → pend[7]=1; md handshake rd=7, v=0x1234 at cycle t with no pipe traffic → regf_we rd_s=7 at t+2, pend[7]=0 after that edge.
- Starvation: FIFO holds one entry, pipe writes every cycle → pipe wins 3 cycles, pipe_hold=1 in the 4th cycle, FIFO entry written the next cycle, pipe_hold then 0.
- Full FIFO: push 4 md results while pipe writes continuously with the hold honoured → md_ready=0 after the 4th push; all 4 results drain in order with correct values; no loss or duplication.
- Hazard/scoreboard: pend[3]=1, dec_rs2_s=3 → hazard=1; dec_rs1_s=0 with pend[0] never set → hazard=0; same-edge issue and pop to x9 → pend[9]=1.
- Reset mid-operation: FIFO holding 2 entries and pend≠0, rst pulled low between edges → regf_we=0, pend=0, md_ready=1 immediately; after release no stale write appears.
